// File: rtl/rr_issue_sched.sv
// Round-robin issue scheduler sharing one in-order pipelined unit between NumReq requesters.
// Issued requester IDs are queued in order so each unit response is steered back to its owner.
module rr_issue_sched #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RspWidth  = 32,
  parameter int unsigned MaxOut    = 4,
  parameter int unsigned IdxWidth  = $clog2(NumReq),
  parameter int unsigned CntWidth  = $clog2(MaxOut + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0]   req_data_i,
  output logic                               unit_valid_o,
  input  logic                               unit_ready_i,
  output logic [DataWidth-1:0]               unit_data_o,
  input  logic                               unit_rsp_valid_i,
  output logic                               unit_rsp_ready_o,
  input  logic [RspWidth-1:0]                unit_rsp_data_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [RspWidth-1:0]                rsp_data_o,
  output logic [CntWidth-1:0]                outstanding_o,
  output logic                               busy_o
);

  localparam int unsigned PtrWidth = (MaxOut > 1) ? $clog2(MaxOut) : 1;

  logic [IdxWidth-1:0] last_q, lock_idx_q;
  logic                lock_q;
  logic [IdxWidth-1:0] id_q [MaxOut];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [IdxWidth-1:0] rr_sel, sel, head;
  logic                enable, issue_fire, retire_fire, cnt_nz;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOut - 1)) ? '0 : p + 1'b1;
  endfunction

  // First valid index after the last grant, wrapping at NumReq.
  always_comb begin
    logic                found;
    logic [IdxWidth-1:0] cand;
    rr_sel = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxWidth'((32'(last_q) + i) % NumReq);
      if (!found && req_valid_i[cand]) begin
        rr_sel = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel          = lock_q ? lock_idx_q : rr_sel;
  // Full queue blocks issue even if a response retires this cycle, keeping rsp->issue acyclic.
  assign enable       = cnt_q < CntWidth'(MaxOut);
  assign unit_valid_o = enable & (|req_valid_i);
  assign unit_data_o  = req_data_i[sel];
  assign issue_fire   = unit_valid_o & unit_ready_i;

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = issue_fire;
  end

  assign cnt_nz           = cnt_q != '0;
  assign head             = id_q[rd_ptr_q];
  assign unit_rsp_ready_o = rsp_ready_i[head] & cnt_nz;
  assign retire_fire      = unit_rsp_valid_i & unit_rsp_ready_o;
  assign rsp_data_o       = unit_rsp_data_i;

  always_comb begin
    rsp_valid_o       = '0;
    rsp_valid_o[head] = unit_rsp_valid_i & cnt_nz;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue_fire, retire_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = cnt_nz | unit_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= IdxWidth'(NumReq - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      last_q     <= IdxWidth'(NumReq - 1);
      lock_q     <= 1'b0;
    end else begin
      if (issue_fire) begin
        last_q <= sel;
        lock_q <= 1'b0;
      end else if (unit_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
    end
  end

  // The ID queue ignores flush so in-flight responses keep routing to their owners.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOut); i++) id_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (issue_fire) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (retire_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_issue_sched.sv
// Directed table-driven bench for rr_issue_sched with hand-computed grants, routing and counts.
module tb_rr_issue_sched;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  flush_i;
  logic [3:0]            req_valid_i;
  logic [3:0]            req_ready_o;
  logic [3:0][31:0]      req_data_i;
  logic                  unit_valid_o;
  logic                  unit_ready_i;
  logic [31:0]           unit_data_o;
  logic                  unit_rsp_valid_i;
  logic                  unit_rsp_ready_o;
  logic [31:0]           unit_rsp_data_i;
  logic [3:0]            rsp_valid_o;
  logic [3:0]            rsp_ready_i;
  logic [31:0]           rsp_data_o;
  logic [2:0]            outstanding_o;
  logic                  busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rr_issue_sched #(
    .NumReq   (4),
    .DataWidth(32),
    .RspWidth (32),
    .MaxOut   (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_data_i       (req_data_i),
    .unit_valid_o     (unit_valid_o),
    .unit_ready_i     (unit_ready_i),
    .unit_data_o      (unit_data_o),
    .unit_rsp_valid_i (unit_rsp_valid_i),
    .unit_rsp_ready_o (unit_rsp_ready_o),
    .unit_rsp_data_i  (unit_rsp_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .outstanding_o    (outstanding_o),
    .busy_o           (busy_o)
  );

  typedef struct {
    logic [3:0] rv;
    logic       ur;
    logic       fl;
    logic       urv;
    logic [3:0] rr;
    logic       e_uv;
    logic [3:0] e_rdy;
    int         e_sel;
    logic [3:0] e_rspv;
    logic       e_urr;
    int         e_outs;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] payload(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  function automatic vec_t mk(input logic [3:0] rv, input logic ur, input logic fl,
                              input logic urv, input logic [3:0] rr, input logic e_uv,
                              input logic [3:0] e_rdy, input int e_sel,
                              input logic [3:0] e_rspv, input logic e_urr, input int e_outs);
    vec_t v;
    v.rv = rv; v.ur = ur; v.fl = fl; v.urv = urv; v.rr = rr;
    v.e_uv = e_uv; v.e_rdy = e_rdy; v.e_sel = e_sel; v.e_rspv = e_rspv;
    v.e_urr = e_urr; v.e_outs = e_outs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush_i          = 1'b0;
    req_valid_i      = 4'h0;
    unit_ready_i     = 1'b1;
    unit_rsp_valid_i = 1'b0;
    rsp_ready_i      = 4'hF;
    unit_rsp_data_i  = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data_i[i] = payload(i);
    drive_idle();
    rst_ni = 1'b0;

    // rv, ur, fl, urv, rr | uv, rdy, sel, rspv, urr, outs
    // All four valid, responses 3 cycles after issue
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0001, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0010, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0100, 2, 4'b0000, 1, 2));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'hF, 1, 4'b1000, 3, 4'b0001, 1, 3));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'hF, 1, 4'b0001, 0, 4'b0010, 1, 3));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'hF, 1, 4'b0010, 1, 4'b0100, 1, 3));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'hF, 1, 4'b0100, 2, 4'b1000, 1, 3));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0001, 1, 3));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0010, 1, 2));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0100, 1, 1));
    // Wrap-around: last=1, requesters 1 and 3 valid
    vecs.push_back(mk(4'b0010, 1, 0, 0, 4'hF, 1, 4'b0010, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b1010, 1, 0, 0, 4'hF, 1, 4'b1000, 3, 4'b0000, 1, 1));
    vecs.push_back(mk(4'b1010, 1, 0, 0, 4'hF, 1, 4'b0010, 1, 4'b0000, 1, 2));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0010, 1, 3));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b1000, 1, 2));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0010, 1, 1));
    // Lock: set last=3, then requester 2 stalls while 0 (higher priority) joins
    vecs.push_back(mk(4'b1000, 1, 0, 0, 4'hF, 1, 4'b1000, 3, 4'b0000, 0, 0));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b1000, 1, 1));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 4'hF, 1, 4'b0000, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0101, 0, 0, 0, 4'hF, 1, 4'b0000, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0101, 0, 0, 0, 4'hF, 1, 4'b0000, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0101, 0, 0, 0, 4'hF, 1, 4'b0000, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0101, 1, 0, 0, 4'hF, 1, 4'b0100, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 0, 0, 4'hF, 1, 4'b0001, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0100, 1, 2));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0001, 1, 1));
    // Fill to MaxOut, full blocks issue even with a retire, then 4,3,4
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0010, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0100, 2, 4'b0000, 1, 1));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b1000, 3, 4'b0000, 1, 2));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0001, 0, 4'b0000, 1, 3));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 0, 4'b0000, 0, 4'b0000, 1, 4));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0010, 1, 4));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 1, 4'b0010, 1, 4'b0000, 1, 3));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'hF, 0, 4'b0000, 0, 4'b0000, 1, 4));
    // Drain to requester 1 at head, then hold its rsp_ready low 2 cycles
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0100, 1, 4));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b1000, 1, 3));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0001, 1, 2));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'b1101, 0, 4'b0000, 0, 4'b0010, 0, 1));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'b1101, 0, 4'b0000, 0, 4'b0010, 0, 1));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0010, 1, 1));
    // Stray response with empty queue is ignored
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0000, 0, 0));
    // Flush with two outstanding: grant restarts at 0, responses still route 2,1
    vecs.push_back(mk(4'b0100, 1, 0, 0, 4'hF, 1, 4'b0100, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 0, 0, 4'hF, 1, 4'b0010, 1, 4'b0000, 1, 1));
    vecs.push_back(mk(4'h0, 1, 1, 0, 4'hF, 0, 4'b0000, 0, 4'b0000, 1, 2));
    vecs.push_back(mk(4'b0101, 0, 0, 1, 4'hF, 1, 4'b0000, 0, 4'b0100, 1, 2));
    vecs.push_back(mk(4'b0101, 0, 0, 1, 4'hF, 1, 4'b0000, 0, 4'b0010, 1, 1));
    vecs.push_back(mk(4'b0101, 1, 0, 0, 4'hF, 1, 4'b0001, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'h0, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0001, 1, 1));
    vecs.push_back(mk(4'h0, 1, 0, 0, 4'hF, 0, 4'b0000, 0, 4'b0000, 0, 0));

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_uv", 32'(unit_valid_o), 32'(1'b0));
    check("rst_rdy", 32'(req_ready_o), 32'(4'h0));
    check("rst_rspv", 32'(rsp_valid_o), 32'(4'h0));
    check("rst_urr", 32'(unit_rsp_ready_o), 32'(1'b0));
    check("rst_outs", 32'(outstanding_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(1'b0));
    check("rst_data", unit_data_o, payload(0));
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      req_valid_i      = vecs[k].rv;
      unit_ready_i     = vecs[k].ur;
      flush_i          = vecs[k].fl;
      unit_rsp_valid_i = vecs[k].urv;
      rsp_ready_i      = vecs[k].rr;
      unit_rsp_data_i  = 32'hC000_0000 + 32'(k);
      @(negedge clk_i);
      check($sformatf("v%0d_uv", k), 32'(unit_valid_o), 32'(vecs[k].e_uv));
      check($sformatf("v%0d_rdy", k), 32'(req_ready_o), 32'(vecs[k].e_rdy));
      if (vecs[k].e_uv)
        check($sformatf("v%0d_data", k), unit_data_o, payload(vecs[k].e_sel));
      check($sformatf("v%0d_rspv", k), 32'(rsp_valid_o), 32'(vecs[k].e_rspv));
      check($sformatf("v%0d_urr", k), 32'(unit_rsp_ready_o), 32'(vecs[k].e_urr));
      check($sformatf("v%0d_outs", k), 32'(outstanding_o), 32'(vecs[k].e_outs));
      check($sformatf("v%0d_busy", k), 32'(busy_o),
            32'((vecs[k].e_outs != 0) || vecs[k].e_uv));
      check($sformatf("v%0d_rdata", k), rsp_data_o, 32'hC000_0000 + 32'(k));
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset mid-operation discards in-flight IDs and the pointer
    drive_idle();
    req_valid_i = 4'b0011;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    req_valid_i      = 4'h0;
    unit_rsp_valid_i = 1'b1;
    #1;
    check("pre_rst_outs", 32'(outstanding_o), 32'(2));
    #1;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_outs", 32'(outstanding_o), 32'(0));
    check("mid_rst_rspv", 32'(rsp_valid_o), 32'(4'h0));
    check("mid_rst_urr", 32'(unit_rsp_ready_o), 32'(1'b0));
    check("mid_rst_busy", 32'(busy_o), 32'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    unit_rsp_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    req_valid_i = 4'b1001;
    @(negedge clk_i);
    check("post_rst_grant", 32'(req_ready_o), 32'(4'b0001));
    @(posedge clk_i);
    #1;
    drive_idle();
    repeat (2) @(posedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
